// File: rtl/wide_alu_seq.sv
// rtl/wide_alu_seq.sv - 16-bit AND/XOR/SHL/SHR/ADD sequencer built on an 8-bit combinational ALU
//
// Purpose: accepts a 16-bit operation and runs it as byte-wide steps on an
// external 8-bit ALU. Carry and shift bits are chained between the low and
// high bytes, and the 16-bit result is registered once the op has finished.
//
// Ports:
//   CLK          in   1   clock, all state on rising edge
//   RESET        in   1   synchronous active-high reset
//   START        in   1   request, accepted only when BUSY=0
//   OP           in   3   000 and, 001 xor, 010 shl, 011 shr, 100 add
//   A            in  16   operand A (value for shifts)
//   B            in  16   operand B (B[0] is the fill bit for shifts)
//   BUSY         out  1   ALU steps in progress
//   DONE         out  1   one-cycle pulse when RESULT/CARRY/ZF16 are valid
//   RESULT       out 16   registered result
//   CARRY        out  1   add carry-out or shifted-out bit
//   ZF16         out  1   RESULT == 0
//   ALU_OP       out  3   to ALU OP
//   ALU_R1       out  8   to ALU R1
//   ALU_R2       out  8   to ALU R2
//   ALU_OUT      in   8   from ALU OUT
//   ALU_OVERFLOW in   2   from ALU OVERFLOW (bit 0 = byte carry)
//   ALU_ZF       in   1   from ALU ZF (unused)

module wide_alu_seq (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [2:0]  OP,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] RESULT,
  output logic        CARRY,
  output logic        ZF16,
  output logic [2:0]  ALU_OP,
  output logic [7:0]  ALU_R1,
  output logic [7:0]  ALU_R2,
  input  logic [7:0]  ALU_OUT,
  input  logic [1:0]  ALU_OVERFLOW,
  input  logic        ALU_ZF
);

  typedef enum logic [2:0] {IDLE, S_LO, S_HI, S_CI, FIN} state_t;

  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [15:0] a_q, b_q;
  logic [7:0]  lo_q;   // low result byte from S_LO
  logic [7:0]  hi_q;   // raw high-byte sum (ADD only), before carry-in
  logic        c0_q;   // low-byte carry, fed into the high byte in S_CI
  logic        c1_q;   // high-byte carry from S_HI
  logic        accept;

  logic unused_inputs;
  assign unused_inputs = ^{ALU_ZF, ALU_OVERFLOW[1]};

  assign accept = START && ((state_q == IDLE) || (state_q == FIN));
  assign BUSY   = (state_q == S_LO) || (state_q == S_HI) || (state_q == S_CI);
  assign DONE   = (state_q == FIN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = S_LO;
      S_LO:    state_d = S_HI;
      // ADD always takes the extra carry-in step so its latency is fixed.
      S_HI:    state_d = (op_q == OP_ADD) ? S_CI : FIN;
      S_CI:    state_d = FIN;
      FIN:     state_d = accept ? S_LO : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU operand steering; the ALU's shl/shr take the carried-in bit from R1.
  always_comb begin
    ALU_OP = 3'b000;
    ALU_R1 = 8'h00;
    ALU_R2 = 8'h00;
    if (BUSY) begin
      ALU_OP = op_q;
      case (op_q)
        OP_SHL: begin
          if (state_q == S_LO) begin
            ALU_R1 = {b_q[0], 7'b0};
            ALU_R2 = a_q[7:0];
          end else begin
            ALU_R1 = a_q[7:0];
            ALU_R2 = a_q[15:8];
          end
        end
        OP_SHR: begin
          if (state_q == S_LO) begin
            ALU_R1 = a_q[15:8];
            ALU_R2 = a_q[7:0];
          end else begin
            ALU_R1 = {7'b0, b_q[0]};
            ALU_R2 = a_q[15:8];
          end
        end
        default: begin
          if (state_q == S_LO) begin
            ALU_R1 = a_q[7:0];
            ALU_R2 = b_q[7:0];
          end else if (state_q == S_HI) begin
            ALU_R1 = a_q[15:8];
            ALU_R2 = b_q[15:8];
          end else begin
            ALU_R1 = hi_q;
            ALU_R2 = {7'b0, c0_q};
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      op_q    <= 3'b000;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
      c0_q    <= 1'b0;
      c1_q    <= 1'b0;
      RESULT  <= 16'h0000;
      CARRY   <= 1'b0;
      ZF16    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= OP;
        a_q  <= A;
        b_q  <= B;
      end
      case (state_q)
        S_LO: begin
          lo_q <= ALU_OUT;
          c0_q <= ALU_OVERFLOW[0];
        end
        S_HI: begin
          if (op_q == OP_ADD) begin
            hi_q <= ALU_OUT;
            c1_q <= ALU_OVERFLOW[0];
          end else begin
            RESULT <= {ALU_OUT, lo_q};
            ZF16   <= ({ALU_OUT, lo_q} == 16'h0000);
            case (op_q)
              OP_SHL:  CARRY <= a_q[15];
              OP_SHR:  CARRY <= a_q[0];
              default: CARRY <= 1'b0;
            endcase
          end
        end
        S_CI: begin
          RESULT <= {ALU_OUT, lo_q};
          ZF16   <= ({ALU_OUT, lo_q} == 16'h0000);
          CARRY  <= c1_q | ALU_OVERFLOW[0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_alu_seq.sv
// tb/tb_wide_alu_seq.sv - scoreboard bench for wide_alu_seq with a behavioural 8-bit ALU

module tb_wide_alu_seq;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [2:0]  OP;
  logic [15:0] A, B;
  logic        BUSY, DONE, CARRY, ZF16;
  logic [15:0] RESULT;
  logic [2:0]  ALU_OP;
  logic [7:0]  ALU_R1, ALU_R2, ALU_OUT;
  logic [1:0]  ALU_OVERFLOW;
  logic        ALU_ZF;

  int checks = 0;
  int failures = 0;
  int done_count = 0;

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        z;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] r1s[3];
  logic [7:0] r2s[3];

  always #5 CLK = ~CLK;

  wide_alu_seq dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .CARRY(CARRY), .ZF16(ZF16),
    .ALU_OP(ALU_OP), .ALU_R1(ALU_R1), .ALU_R2(ALU_R2),
    .ALU_OUT(ALU_OUT), .ALU_OVERFLOW(ALU_OVERFLOW), .ALU_ZF(ALU_ZF)
  );

  // Behavioural model of the existing 8-bit ALU.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum      = {1'b0, ALU_R1} + {1'b0, ALU_R2};
    ALU_OUT      = 8'h00;
    ALU_OVERFLOW = 2'b00;
    case (ALU_OP)
      3'b000: ALU_OUT = ALU_R1 & ALU_R2;
      3'b001: ALU_OUT = ALU_R1 ^ ALU_R2;
      3'b010: ALU_OUT = {ALU_R2[6:0], ALU_R1[7]};
      3'b011: ALU_OUT = {ALU_R1[0], ALU_R2[7:1]};
      3'b100: begin
        ALU_OUT         = alu_sum[7:0];
        ALU_OVERFLOW[0] = alu_sum[8];
      end
      default: ;
    endcase
    ALU_ZF = (ALU_OUT == 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every DONE pulse must match the oldest expectation.
  always @(negedge CLK) begin
    if (!RESET && DONE) begin
      done_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", {16'h0, RESULT}, {16'h0, e.r});
        chk("carry", {31'h0, CARRY}, {31'h0, e.c});
        chk("zf16", {31'h0, ZF16}, {31'h0, e.z});
      end
    end
  end

  // Issues an op from the current time; returns at the negedge of the DONE cycle.
  task automatic run_op(input string name, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er, input logic ec,
                        input logic ez, input int elat, input int ebusy, input bit glitch);
    exp_t e;
    int lat, busy, n;
    bit seen;
    e.r = er; e.c = ec; e.z = ez;
    exp_q.push_back(e);
    OP = op; A = a; B = b; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    lat = 1; busy = 0; n = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge CLK);
      if (glitch && lat == 1) begin
        START = 1'b1;
        OP    = 3'b000;
      end
      if (glitch && lat == 2) START = 1'b0;
      if (BUSY) begin
        busy++;
        if (n < 3) begin
          r1s[n] = ALU_R1;
          r2s[n] = ALU_R2;
          n++;
        end
      end
      if (DONE) seen = 1;
      else lat++;
    end
    chk({name, "_latency"}, lat, elat);
    chk({name, "_busy_cycles"}, busy, ebusy);
  endtask

  initial begin
    int dc;
    RESET = 1'b1; START = 1'b0; OP = 3'b000; A = 16'h0; B = 16'h0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", {31'h0, BUSY}, 32'h0);
    chk("rst_done", {31'h0, DONE}, 32'h0);
    chk("rst_result", {16'h0, RESULT}, 32'h0);
    chk("rst_carry_zf", {30'h0, CARRY, ZF16}, 32'h0);
    chk("rst_alu", {13'h0, ALU_OP, ALU_R1, ALU_R2}, 32'h0);
    RESET = 1'b0;
    @(negedge CLK);

    // 1: ADD with carry from low into high byte
    run_op("add1", 3'b100, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 4, 3, 0);
    chk("add1_step_lo", {16'h0, r1s[0], r2s[0]}, 32'h0000FF01);
    chk("add1_step_hi", {16'h0, r1s[1], r2s[1]}, 32'h00000000);
    chk("add1_step_ci", {16'h0, r1s[2], r2s[2]}, 32'h00000001);
    repeat (2) @(negedge CLK);

    // 2: ADD overflow to zero
    run_op("add2", 3'b100, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 4, 3, 0);
    repeat (2) @(negedge CLK);

    // 3: SHL then back-to-back SHR issued during FIN
    run_op("shl", 3'b010, 16'h8081, 16'h0001, 16'h0103, 1'b1, 1'b0, 3, 2, 0);
    run_op("shr", 3'b011, 16'h0181, 16'h0001, 16'h80C0, 1'b1, 1'b0, 3, 2, 0);
    repeat (2) @(negedge CLK);

    // 4: XOR to zero with an ignored AND request while busy
    dc = done_count;
    run_op("xor", 3'b001, 16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, 1'b1, 3, 2, 1);
    repeat (5) @(negedge CLK);
    chk("xor_single_done", done_count - dc, 1);
    chk("xor_result_kept", {16'h0, RESULT}, 32'h0);

    // 5: AND, then hold through idle cycles
    run_op("and", 3'b000, 16'hF00F, 16'h0FFF, 16'h000F, 1'b0, 1'b0, 3, 2, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("and_hold_result", {16'h0, RESULT}, 32'h000F);
      chk("and_hold_done", {31'h0, DONE}, 32'h0);
    end

    // 6: reset during S_HI of an ADD
    OP = 3'b100; A = 16'h1234; B = 16'h1111; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("abort_in_s_hi", {16'h0, r1s[0] & 8'h00 | ALU_R1, ALU_R2}, 32'h00001211);
    RESET = 1'b1;
    @(negedge CLK);
    chk("abort_busy", {31'h0, BUSY}, 32'h0);
    chk("abort_done", {31'h0, DONE}, 32'h0);
    chk("abort_result", {16'h0, RESULT}, 32'h0);
    chk("abort_alu", {13'h0, ALU_OP, ALU_R1, ALU_R2}, 32'h0);
    RESET = 1'b0;
    dc = done_count;
    repeat (4) @(negedge CLK);
    chk("abort_no_done", done_count - dc, 0);
    run_op("add3", 3'b100, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 4, 3, 0);
    repeat (2) @(negedge CLK);

    // Simultaneous RESET and START: START must be dropped
    RESET = 1'b1; START = 1'b1; OP = 3'b100;
    @(negedge CLK);
    RESET = 1'b0; START = 1'b0;
    @(negedge CLK);
    chk("rst_start_busy", {31'h0, BUSY}, 32'h0);
    repeat (3) @(negedge CLK);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
